product_fifo: RTL and testbench
===============================

// Module: product_fifo
// PURPOSE
//   Output buffer directly downstream of the approximate 16x16 multiplier datapath.
//   Captures each 32-bit product {reg1_out, reg2_out} when the multiplier controller
//   signals completion, and holds it until a consumer takes it over a valid/ready handshake.
//   Back-pressure (in_ready) tells the controller not to start a new multiply while the buffer is full.
// PARAMETERS
//   WIDTH  32  product width in bits
//   DEPTH  4   number of entries; power of two, >= 2
// PORTS
//   clk        in   1         rising-edge clock; the only clock
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   1         one-cycle pulse: product on in_data is final
//   in_data    in   WIDTH     product from the multiplier datapath
//   in_ready   out  1         1 = an entry is free; controller may start a multiply
//   out_valid  out  1         head entry is available
//   out_data   out  WIDTH     head entry; first-word fall-through
//   out_ready  in   1         consumer accepts the head this cycle
//   overflow   out  1         sticky flag: a push was dropped while full
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): pointers=0, out_valid=0, in_ready=1, overflow=0.
//     out_data after reset is don't-care. Reset mid-stream discards all entries.
//   - Push at a clk edge when in_valid & in_ready: write mem[wr_ptr], then wr_ptr+1.
//   - Pop at a clk edge when out_valid & out_ready: rd_ptr+1.
//   - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//     empty = (ptrs equal). full = (MSBs differ, rest equal).
//   - out_valid = !empty. in_ready = !full. Both are decoded from registered
//     pointers only; there is no combinational path from in to out.
//   - out_data = mem[rd_ptr] combinationally, so it is valid in the cycle after the push.
//     Latency from push to out_valid is 1 cycle.
//   - Push and pop in the same cycle (not empty, not full): both occur, occupancy unchanged.
//   - Full + pop + in_valid: push is rejected, because in_ready was 0 that cycle.
//     overflow is set. There is no pass-through.
//   - Empty + in_valid: push only. A pop is impossible while out_valid=0.
//   - in_valid while !in_ready: data dropped, pointers unchanged, overflow<=1.
//     overflow stays 1 until rst.
//   - out_ready while !out_valid: ignored.
//   - Data is stored bit-exact; no arithmetic on the product.
// CONFIGURATION
//   - PRODUCT_FIFO_COUNT_EN defined:
//     adds output port count [log2(DEPTH):0] = wr_ptr - rd_ptr (occupancy, 0..DEPTH).
//     Registered, reset 0, updates on the same edge as the pointers.
//   - Undefined: the port does not exist and no occupancy logic is built.
// STRUCTURE
//   - Package product_fifo_pkg:
//     PROD_W = 32 constant
//     ptr_t typedef
//     function ptr_w(DEPTH) returning log2(DEPTH)+1
//   - Sub-module product_fifo_mem: DEPTH x WIDTH register array,
//     one synchronous write port, one asynchronous read port. No reset on storage.
//   - Top holds the pointers, the full/empty decode, overflow, and the optional count.
// TESTING
//   1. Reset, then one push of 32'h0003_0005: out_valid=1 next cycle, out_data=32'h0003_0005.
//      Pop it: out_valid=0, in_ready=1.
//   2. Push 32'h1, 32'h2, 32'h3, 32'h4 with out_ready=0: in_ready=0 after the 4th.
//      Drain order is 1,2,3,4.
//   3. Full, then in_valid with 32'hDEAD_BEEF: overflow=1 and stays 1.
//      Drained data excludes DEAD_BEEF.
//   4. Occupancy 2, push and pop in the same cycle repeated 10 times:
//      occupancy stays 2, FIFO order preserved across pointer wrap.
//   5. Occupancy 3, assert rst for 1 cycle: out_valid=0, in_ready=1, overflow=0.
//      A following push of 32'h7 is read back as 32'h7.
//   6. With PRODUCT_FIFO_COUNT_EN: count follows 0->1->2->1->0 for push, push, pop, pop.
//      Reads DEPTH when full.

Source files
------------

// File: rtl/product_fifo_pkg.sv
// Shared constants and pointer sizing for the multiplier product FIFO.
package product_fifo_pkg;

    localparam int PROD_W    = 32;
    localparam int DEF_DEPTH = 4;

    // One extra pointer bit tells full apart from empty when the address bits match.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_w(DEF_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/product_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port and one asynchronous read port.
// The storage has no reset. Entries are only read once they have been written.
module product_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/product_fifo.sv
// First-word fall-through buffer for products from the approximate multiplier.
// Optional occupancy port is enabled by defining PRODUCT_FIFO_COUNT_EN.
module product_fifo
    import product_fifo_pkg::*;
#(
    parameter int WIDTH = PROD_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   overflow
`ifdef PRODUCT_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    // Flags come only from registered pointers, so in_* never reaches out_* combinationally.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = out_ready & ~w_empty;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (in_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    product_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (out_data)
    );

`ifdef PRODUCT_FIFO_COUNT_EN
    logic [PW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (w_push && !w_pop)
            r_count <= r_count + 1'b1;
        else if (w_pop && !w_push)
            r_count <= r_count - 1'b1;
    end

    assign count = r_count;
`endif

endmodule

// File: tb/tb_product_fifo.sv
// Randomized + directed bench for product_fifo with a queue-based reference model.
module tb_product_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         overflow;
`ifdef PRODUCT_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as a queue plus the sticky overflow flag.
    logic [W-1:0] exp_q[$];
    logic         mdl_ovf = 1'b0;

    product_fifo #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef PRODUCT_FIFO_COUNT_EN
        ,
        .count     (count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples; inputs are stable here.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            mdl_ovf = 1'b0;
        end else begin
            int sz;
            sz = exp_q.size();
            if (out_ready && sz > 0)
                void'(exp_q.pop_front());
            if (in_valid) begin
                if (sz < DEPTH)
                    exp_q.push_back(in_data);
                else
                    mdl_ovf = 1'b1;
            end
        end
    end

    // Monitor: compare the DUT against the model mid-cycle.
    always @(negedge clk) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
        chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_q.size() < DEPTH});
        chk("overflow",  {31'b0, overflow},  {31'b0, mdl_ovf});
        if (exp_q.size() != 0)
            chk("out_data", out_data, exp_q[0]);
`ifdef PRODUCT_FIFO_COUNT_EN
        chk("count", W'(count), W'(exp_q.size()));
`endif
    end

    // Drive one cycle of inputs, then settle just after the sampling edge.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] d, input logic ordy);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);

        // single product, then pop
        step(0, 1, 32'h0003_0005, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);

        // fill then drain in order
        for (int i = 1; i <= 4; i++) step(0, 1, W'(i), 0);
        chk("full_in_ready", {31'b0, in_ready}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);

        // overflow while full, including push+pop on a full buffer
        for (int i = 1; i <= 4; i++) step(0, 1, W'(32'h100 + i), 0);
        step(0, 1, 32'hDEAD_BEEF, 0);
        step(0, 1, 32'hDEAD_BEEF, 1);
        chk("ovf_set", {31'b0, overflow}, 32'h1);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        chk("ovf_sticky", {31'b0, overflow}, 32'h1);

        // steady occupancy 2 with simultaneous push/pop across pointer wrap
        step(0, 1, 32'hA0, 0);
        step(0, 1, 32'hA1, 0);
        for (int i = 2; i < 12; i++) step(0, 1, W'(32'hA0 + i), 1);
`ifdef PRODUCT_FIFO_COUNT_EN
        chk("occ2_count", W'(count), 32'd2);
`endif
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // mid-stream reset discards contents
        for (int i = 0; i < 3; i++) step(0, 1, W'(32'h50 + i), 0);
        step(1, 0, '0, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_ovf",   {31'b0, overflow},  32'h0);
        step(0, 1, 32'h7, 0);
        chk("after_rst_data", out_data, 32'h7);
        step(0, 0, '0, 1);

        // randomized traffic with rare resets
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 6; i++) step(0, 0, '0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
